// File: rtl/drain_requant_packer.sv
// Drains one PE column, requantises each accumulator (round, shift, saturate) and packs the
// precision lanes into DATA_WIDTH words held in an output FIFO with valid/ready handshake.
module drain_requant_packer #(
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  start_ack,
  input  logic [1:0]            precision_mode,
  input  logic [5:0]            shift,
  input  logic [ACC_WIDTH-1:0]  acc_in,
  output logic                  drain_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sat_count,
  output logic                  mode_err
);

  typedef enum logic [1:0] {
    ModeInt4  = 2'd0,
    ModeInt8  = 2'd1,
    ModeInt16 = 2'd2,
    ModeRsvd  = 2'd3
  } precision_mode_t;

  typedef enum logic [1:0] {StIdle = 2'd0, StDrain = 2'd1, StFlush = 2'd2} state_e;

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned AW   = ACC_WIDTH + 1;

  state_e                state_q;
  precision_mode_t       mode_q;
  precision_mode_t       req_mode;
  logic [5:0]            shift_q;
  logic [RowW-1:0]       row_q;
  logic                  done_q, mode_err_q, err_hold_q;
  logic [15:0]           sat_q;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, words_need, free_entries;
  logic                  push, pop;

  logic signed [AW-1:0]  ext, rnd, shr, hi, lo;
  logic                  clip;
  logic [DATA_WIDTH-1:0] lane_mask, lane_raw, lane_d;

  logic [DATA_WIDTH-1:0] req_q, word_q, word_next;
  logic                  req_valid_q, req_last_q;
  logic [1:0]            lane_q, lane_last;

  assign req_mode = precision_mode_t'(precision_mode);

  always_comb begin
    unique case (req_mode)
      ModeInt4: words_need = CntW'((ROWS + 3) / 4);
      ModeInt8: words_need = CntW'((ROWS + 1) / 2);
      default:  words_need = CntW'(ROWS);
    endcase
  end

  assign free_entries = CntW'(FIFO_DEPTH) - count_q;
  // Admission reserves room for the whole request because a drain cannot be stalled.
  assign start_ack    = !rst && (state_q == StIdle) && start && (req_mode != ModeRsvd) &&
                        (free_entries >= words_need);
  assign drain_enable = (state_q == StDrain);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign mode_err     = mode_err_q;
  assign sat_count    = sat_q;

  // Stage 1: one extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    ext = $signed({acc_in[ACC_WIDTH-1], acc_in});
    rnd = '0;
    if (shift_q != 6'd0) rnd = $signed(AW'(1) << (shift_q - 6'd1));
    shr = (ext + rnd) >>> shift_q;
    unique case (mode_q)
      ModeInt4: begin
        hi        = $signed(AW'(7));
        lane_mask = DATA_WIDTH'(4'hF);
      end
      ModeInt8: begin
        hi        = $signed(AW'(127));
        lane_mask = DATA_WIDTH'(8'hFF);
      end
      default: begin
        hi        = $signed(AW'(32767));
        lane_mask = DATA_WIDTH'(16'hFFFF);
      end
    endcase
    lo   = ~hi;
    clip = 1'b0;
    if (shr > hi) begin
      lane_raw = hi[DATA_WIDTH-1:0];
      clip     = 1'b1;
    end else if (shr < lo) begin
      lane_raw = lo[DATA_WIDTH-1:0];
      clip     = 1'b1;
    end else begin
      lane_raw = shr[DATA_WIDTH-1:0];
    end
    lane_d = lane_raw & lane_mask;
  end

  // Stage 2: merge the registered lane into the word being assembled.
  always_comb begin
    unique case (mode_q)
      ModeInt4: begin
        lane_last = 2'd3;
        word_next = word_q | (req_q << {lane_q, 2'b00});
      end
      ModeInt8: begin
        lane_last = 2'd1;
        word_next = word_q | (req_q << {lane_q, 3'b000});
      end
      default: begin
        lane_last = 2'd0;
        word_next = req_q;
      end
    endcase
  end

  assign push      = req_valid_q && ((lane_q == lane_last) || req_last_q);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= ModeInt4;
      shift_q    <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
      err_hold_q <= 1'b0;
      sat_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
      if (!start) err_hold_q <= 1'b0;
      if (drain_enable && clip && (sat_q != 16'hFFFF)) sat_q <= sat_q + 16'd1;
      unique case (state_q)
        StIdle: begin
          if (start && (req_mode == ModeRsvd)) begin
            // One pulse per held request; the requester has to drop start to retry.
            mode_err_q <= !err_hold_q;
            err_hold_q <= 1'b1;
          end else if (start_ack) begin
            mode_q  <= req_mode;
            shift_q <= shift;
            sat_q   <= '0;
            row_q   <= '0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          row_q <= row_q + RowW'(1);
          if (row_q == RowW'(ROWS - 1)) state_q <= StFlush;
        end
        StFlush: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_last_q  <= 1'b0;
      req_q       <= '0;
      word_q      <= '0;
      lane_q      <= '0;
    end else begin
      req_valid_q <= drain_enable;
      req_last_q  <= drain_enable && (row_q == RowW'(ROWS - 1));
      req_q       <= lane_d;
      if (push) begin
        word_q <= '0;
        lane_q <= '0;
      end else if (req_valid_q) begin
        word_q <= word_next;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_drain_requant_packer.sv
// Bench for drain_requant_packer: directed cases plus randomised requests scored against a
// lane/word model built from the requantisation and packing rules.
module tb_drain_requant_packer;
  localparam int ROWS = 4;
  localparam int FD   = 8;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [1:0]  precision_mode;
  logic [5:0]  shift;
  logic [63:0] acc_in;
  logic        start_ack, drain_enable, out_valid, busy, done, mode_err;
  logic [15:0] out_data, sat_count;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] acc_vec [ROWS];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  drain_requant_packer #(
    .ACC_WIDTH (64),
    .DATA_WIDTH(16),
    .ROWS      (ROWS),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_ack     (start_ack),
    .precision_mode(precision_mode),
    .shift         (shift),
    .acc_in        (acc_in),
    .drain_enable  (drain_enable),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done),
    .sat_count     (sat_count),
    .mode_err      (mode_err)
  );

  // Reference lane: round-half-up shift in 65-bit arithmetic, clamp, keep the low b bits.
  function automatic logic [15:0] m_lane(input logic [63:0] a, input int s, input int b,
                                         output bit c);
    logic signed [64:0] v, hi, lo;
    v = $signed({a[63], a});
    if (s > 0) v = v + (65'sd1 <<< (s - 1));
    v  = v >>> s;
    hi = (65'sd1 <<< (b - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (b - 1));
    c  = 1'b0;
    if (v > hi) begin v = hi; c = 1'b1; end
    else if (v < lo) begin v = lo; c = 1'b1; end
    return v[15:0] & ((b == 16) ? 16'hFFFF : 16'((1 << b) - 1));
  endfunction

  task automatic model_req(input logic [1:0] m, input int s, output int nsat);
    int          lanes, b, nw;
    logic [15:0] w [ROWS];
    logic [15:0] ln;
    bit          c;
    lanes = (m == 2'd0) ? 4 : (m == 2'd1) ? 2 : 1;
    b     = 16 / lanes;
    nw    = (ROWS + lanes - 1) / lanes;
    nsat  = 0;
    for (int i = 0; i < ROWS; i++) w[i] = '0;
    for (int k = 0; k < ROWS; k++) begin
      ln = m_lane(acc_vec[k], s, b, c);
      if (c) nsat++;
      w[k / lanes] = w[k / lanes] | 16'(ln << ((k % lanes) * b));
    end
    for (int i = 0; i < nw; i++) exp_q.push_back(w[i]);
  endtask

  function automatic logic [63:0] rand_acc();
    logic signed [63:0] v;
    v = $signed({$urandom, $urandom});
    case ($urandom_range(0, 4))
      0:       v = v >>> 57;
      1:       v = v >>> 44;
      2:       v = v >>> 30;
      3:       v = v;
      default: v = ($urandom_range(0, 1) != 0) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                                : 64'sh8000_0000_0000_0000;
    endcase
    return v;
  endfunction

  // Request, drive acc_vec through the drain window, and record what was seen.
  task automatic issue(input logic [1:0] m, input logic [5:0] s, output bit acked,
                       output int waits, output int drains, output logic [2:0] dmask);
    @(negedge clk);
    start = 1'b1; precision_mode = m; shift = s;
    waits = 0; drains = 0; dmask = '0;
    #1;
    while (!start_ack && waits < 100) begin @(negedge clk); waits++; #1; end
    acked = start_ack;
    if (!acked) begin start = 1'b0; return; end
    for (int k = 0; k < ROWS; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; precision_mode = 2'($urandom); shift = 6'($urandom);
      end
      acc_in = acc_vec[k];
      #1;
      if (drain_enable) drains++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      acc_in = {$urandom, $urandom};
      #1;
      if (c == 0 && drain_enable) drains++;
      dmask[c] = done;
    end
  endtask

  task automatic pop_word(output logic [15:0] w, output bit ok);
    @(negedge clk);
    out_ready = 1'b1; ok = 1'b0; w = '0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (out_valid) begin w = out_data; ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; precision_mode = 2'd2;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({drain_enable, out_valid, busy, done, start_ack, mode_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000000",
               {drain_enable, out_valid, busy, done, start_ack, mode_err});
    end
    tests++;
    if ({sat_count, out_data} !== 32'h0) begin
      fails++; $display("FAIL reset_data: sat=%h data=%h want 0", sat_count, out_data);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({drain_enable, out_valid, busy, done} !== 4'b0) begin
      fails++; $display("FAIL reset_release: got %b want 0000",
                        {drain_enable, out_valid, busy, done});
    end
  endtask

  task automatic test_int16_sat();
    logic [15:0] exp [4] = '{16'h0005, 16'hFFFD, 16'h7FFF, 16'h8000};
    logic [15:0] w; bit ok, acked; int waits, drains; logic [2:0] dm;
    acc_vec[0] = 64'd5; acc_vec[1] = -64'sd3; acc_vec[2] = 64'd40000; acc_vec[3] = -64'sd40000;
    issue(2'd2, 6'd0, acked, waits, drains, dm);
    tests++;
    if (!acked || drains != ROWS) begin
      fails++; $display("FAIL int16_drain: ack=%0d drains=%0d want 1/%0d", acked, drains, ROWS);
    end
    tests++;
    if (dm !== 3'b010) begin fails++; $display("FAIL int16_done: got %b want 010", dm); end
    tests++;
    if (sat_count !== 16'd2) begin fails++; $display("FAIL int16_sat: got %0d want 2", sat_count); end
    for (int i = 0; i < 4; i++) begin
      pop_word(w, ok);
      tests++;
      if (!ok || w !== exp[i]) begin
        fails++; $display("FAIL int16_word%0d: got %h ok=%0d want %h", i, w, ok, exp[i]);
      end
    end
  endtask

  task automatic test_int8_round();
    logic [15:0] exp [2] = '{16'h0102, 16'h7FFF};
    logic [15:0] w; bit ok, acked; int waits, drains; logic [2:0] dm;
    acc_vec[0] = 64'h18; acc_vec[1] = 64'h17; acc_vec[2] = -64'sh18; acc_vec[3] = 64'h7FF;
    issue(2'd1, 6'd4, acked, waits, drains, dm);
    tests++;
    if (!acked || dm !== 3'b010) begin
      fails++; $display("FAIL int8_req: ack=%0d done=%b want 1/010", acked, dm);
    end
    tests++;
    if (sat_count !== 16'd1) begin fails++; $display("FAIL int8_sat: got %0d want 1", sat_count); end
    for (int i = 0; i < 2; i++) begin
      pop_word(w, ok);
      tests++;
      if (!ok || w !== exp[i]) begin
        fails++; $display("FAIL int8_word%0d: got %h ok=%0d want %h", i, w, ok, exp[i]);
      end
    end
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL int8_extra: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_int4_pack();
    logic [15:0] w; bit ok, acked; int waits, drains; logic [2:0] dm;
    acc_vec[0] = 64'd1; acc_vec[1] = 64'd2; acc_vec[2] = -64'sd1; acc_vec[3] = 64'd9;
    issue(2'd0, 6'd0, acked, waits, drains, dm);
    tests++;
    if (!acked || sat_count !== 16'd1) begin
      fails++; $display("FAIL int4_sat: ack=%0d sat=%0d want 1/1", acked, sat_count);
    end
    pop_word(w, ok);
    tests++;
    if (!ok || w !== 16'h7F21) begin fails++; $display("FAIL int4_word: got %h ok=%0d want 7f21", w, ok); end
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL int4_single: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_mode_err();
    int errs = 0, bad = 0, errs2 = 0;
    @(negedge clk);
    start = 1'b1; precision_mode = 2'd3;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mode_err) errs++;
      if (start_ack || drain_enable || out_valid || busy) bad++;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mode_err) errs2++;
      if (start_ack || drain_enable || out_valid) bad++;
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (errs != 1) begin fails++; $display("FAIL mode_err_pulse: got %0d pulses want 1", errs); end
    tests++;
    if (errs2 != 1) begin fails++; $display("FAIL mode_err_retry: got %0d pulses want 1", errs2); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL mode_err_drop: %0d active cycles want 0", bad); end
  endtask

  task automatic test_fifo_full();
    logic [15:0] w, e; bit ok, acked; int waits, drains, ns, blocked;
    logic [2:0] dm;
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < ROWS; k++) acc_vec[k] = rand_acc();
      model_req(2'd2, 3, ns);
      issue(2'd2, 6'd3, acked, waits, drains, dm);
      tests++;
      if (!acked || waits != 0) begin
        fails++; $display("FAIL full_req%0d: ack=%0d waits=%0d want 1/0", r, acked, waits);
      end
    end
    blocked = 0;
    @(negedge clk);
    start = 1'b1; precision_mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      #1; if (start_ack || drain_enable) blocked++; @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop_word(w, ok); e = exp_q.pop_front();
      tests++;
      if (!ok || w !== e) begin fails++; $display("FAIL full_pop%0d: got %h want %h", i, w, e); end
    end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; if (start_ack || drain_enable) blocked++; @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (blocked != 0) begin fails++; $display("FAIL full_blocked: %0d early grants want 0", blocked); end
    pop_word(w, ok); e = exp_q.pop_front();
    tests++;
    if (!ok || w !== e) begin fails++; $display("FAIL full_pop3: got %h want %h", w, e); end
    for (int k = 0; k < ROWS; k++) acc_vec[k] = rand_acc();
    model_req(2'd2, 0, ns);
    issue(2'd2, 6'd0, acked, waits, drains, dm);
    tests++;
    if (!acked || waits != 0 || drains != ROWS) begin
      fails++; $display("FAIL full_req3: ack=%0d waits=%0d drains=%0d want 1/0/%0d",
                        acked, waits, drains, ROWS);
    end
    for (int i = 0; i < 8; i++) begin
      pop_word(w, ok); e = exp_q.pop_front();
      tests++;
      if (!ok || w !== e) begin fails++; $display("FAIL full_drain%0d: got %h want %h", i, w, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] cap [$];
    logic [15:0] w, e;
    bit ok;
    int acks = 0, prev = -1, gap = 99, ns = 0, s;
    s = $urandom_range(0, 8);
    exp_q.delete();
    @(negedge clk);
    start = 1'b1; precision_mode = 2'd1; shift = 6'(s);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (acks == 2) start = 1'b0;
      acc_in = rand_acc();
      #1;
      if (drain_enable) begin
        cap.push_back(acc_in);
        if (prev >= 0 && i - prev > 1) gap = i - prev - 1;
        prev = i;
      end
      if (start_ack) acks++;
    end
    tests++;
    if (acks != 2 || cap.size() != 2 * ROWS) begin
      fails++; $display("FAIL b2b_count: acks=%0d captured=%0d want 2/%0d", acks, cap.size(), 2 * ROWS);
    end
    tests++;
    if (gap < 2 || gap == 99) begin fails++; $display("FAIL b2b_gap: got %0d want >=2", gap); end
    if (cap.size() == 2 * ROWS) begin
      for (int r = 0; r < 2; r++) begin
        for (int k = 0; k < ROWS; k++) acc_vec[k] = cap[r * ROWS + k];
        model_req(2'd1, s, ns);
      end
      tests++;
      if (sat_count !== 16'(ns)) begin
        fails++; $display("FAIL b2b_sat: got %0d want %0d", sat_count, ns);
      end
      while (exp_q.size() > 0) begin
        pop_word(w, ok); e = exp_q.pop_front();
        tests++;
        if (!ok || w !== e) begin fails++; $display("FAIL b2b_word: got %h ok=%0d want %h", w, ok, e); end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] w, e; bit ok, acked; int waits, drains, ns, s;
    logic [2:0] dm; logic [1:0] m;
    exp_q.delete();
    for (int r = 0; r < 12; r++) begin
      m = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       s = 0;
        1:       s = 63;
        default: s = $urandom_range(1, 40);
      endcase
      for (int k = 0; k < ROWS; k++) acc_vec[k] = rand_acc();
      model_req(m, s, ns);
      issue(m, 6'(s), acked, waits, drains, dm);
      tests++;
      if (!acked || drains != ROWS || dm !== 3'b010) begin
        fails++; $display("FAIL rand%0d_ctrl: ack=%0d drains=%0d done=%b want 1/%0d/010",
                          r, acked, drains, dm, ROWS);
      end
      tests++;
      if (sat_count !== 16'(ns)) begin
        fails++; $display("FAIL rand%0d_sat: got %0d want %0d", r, sat_count, ns);
      end
      while (exp_q.size() > 0) begin
        pop_word(w, ok); e = exp_q.pop_front();
        tests++;
        if (!ok || w !== e) begin
          fails++; $display("FAIL rand%0d_word: mode=%0d shift=%0d got %h ok=%0d want %h",
                            r, m, s, w, ok, e);
        end
      end
    end
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rand_empty: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    bit acked; int waits, drains, active = 0; logic [2:0] dm;
    for (int k = 0; k < ROWS; k++) acc_vec[k] = rand_acc();
    issue(2'd2, 6'd0, acked, waits, drains, dm);
    @(negedge clk);
    start = 1'b1; precision_mode = 2'd2; shift = 6'd0; waits = 0;
    #1;
    while (!start_ack && waits < 100) begin @(negedge clk); waits++; #1; end
    tests++;
    if (start_ack !== 1'b1) begin fails++; $display("FAIL rstmid_ack: got %b want 1", start_ack); end
    @(negedge clk);
    start = 1'b0; acc_in = rand_acc();
    #1;
    tests++;
    if ({drain_enable, busy, out_valid} !== 3'b111) begin
      fails++; $display("FAIL rstmid_pre: got %b want 111", {drain_enable, busy, out_valid});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({drain_enable, busy, out_valid, done} !== 4'b0 || sat_count !== 16'd0) begin
      fails++; $display("FAIL rstmid_post: flags=%b sat=%0d want 0000/0",
                        {drain_enable, busy, out_valid, done}, sat_count);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (done || drain_enable || out_valid) active++;
    end
    tests++;
    if (active != 0) begin fails++; $display("FAIL rstmid_quiet: %0d active cycles want 0", active); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    precision_mode = 2'd0; shift = 6'd0; acc_in = '0;
    test_reset();
    test_int16_sat();
    test_int8_round();
    test_int4_pack();
    test_mode_err();
    test_fifo_full();
    test_back_to_back();
    test_random();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
